hx8357_dbi_engine: RTL and testbench
====================================

HX8357_DBI_ENGINE -- requirements
Module: hx8357_dbi_engine

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, bus width (legal 8, 9, 16, 18); WR_LOW_CYC, default 2, WRx low cycles; WR_HIGH_CYC, default 2, WRx high cycles; RD_LOW_CYC, default 8, RDx low cycles; RD_HIGH_CYC, default 4, RDx high cycles; RST_LOW_CYC, default 250, RESx low cycles; RST_WAIT_CYC, default 3000000, post-reset wait cycles; every *_CYC value is >=1.
REQ-002 SHALL have ports (name direction width meaning):
 clk  in  1  single clock; all logic rising-edge
 res  in  1  reset, asynchronous, active-high
 req_valid  in  1  request present
 req_ready  out  1  request accepted when high with req_valid
 req_dc  in  1  0 = command beat, 1 = data beat
 req_rd  in  1  1 = read beat, 0 = write beat
 req_last  in  1  release CSx after this beat
 req_data  in  DATA_W  write payload
 hw_reset  in  1  single-cycle pulse starting the display reset sequence
 rsp_valid  out  1  one-cycle pulse, read data valid
 rsp_data  out  DATA_W  read data
 busy  out  1  high in every state except IDLE
 CSx, RESx, DCx, WRx, RDx  out  1 each  8080 display strobes, active-low
 DATAx_o  out  DATA_W  bus drive value
 DATAx_oe  out  1  bus drive enable; tristate buffer is external
 DATAx_i  in  DATA_W  bus sample value

Function
REQ-003 SHALL implement the states RST_LOW, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH, RD_LOW, RD_HIGH; every output SHALL be registered.
REQ-004 RST_LOW SHALL hold RESx=0 and CSx=1 for RST_LOW_CYC cycles, then enter RST_WAIT.
REQ-005 RST_WAIT SHALL hold RESx=1 for RST_WAIT_CYC cycles, then enter IDLE.
REQ-006 req_ready SHALL be 1 only in IDLE and 0 in every other state.
REQ-007 An accept SHALL latch req_dc, req_rd, req_last and req_data, then enter SETUP: CSx=0, DCx=req_dc, one cycle.
REQ-008 On a write, SETUP SHALL set DATAx_oe=1 and DATAx_o=req_data, holding both stable until WR_HIGH ends.
REQ-009 WR_LOW SHALL drive WRx=0 for WR_LOW_CYC cycles, then WR_HIGH SHALL drive WRx=1 for WR_HIGH_CYC cycles.
REQ-010 On a read, SETUP SHALL set DATAx_oe=0, which SHALL stay 0 until the beat ends.
REQ-011 RD_LOW SHALL drive RDx=0 for RD_LOW_CYC cycles and sample DATAx_i into rsp_data on its final cycle.
REQ-012 RD_HIGH SHALL drive RDx=1 for RD_HIGH_CYC cycles; rsp_valid SHALL pulse on its first cycle.
REQ-013 rsp_data SHALL hold its value until the next read sample.
REQ-014 At beat end the block SHALL return to IDLE: if req_last=1, CSx=1 and DATAx_oe=0 in IDLE; if req_last=0, CSx stays 0 (burst open).
REQ-015 An accept while a burst is open SHALL keep CSx=0 with no high glitch.
REQ-016 WRx and RDx SHALL never be 0 simultaneously.
REQ-017 DCx SHALL change only in SETUP.
REQ-018 Minimum write beat SHALL be 1+WR_LOW_CYC+WR_HIGH_CYC cycles, accept to IDLE.
REQ-019 Minimum read beat SHALL be 1+RD_LOW_CYC+RD_HIGH_CYC cycles, accept to IDLE.
REQ-020 A hw_reset pulse SHALL be honoured in any state:
 - aborts any beat in flight, no rsp_valid
 - next cycle: CSx=1, WRx=1, RDx=1, DATAx_oe=0, state RST_LOW
 - hw_reset and req_valid in the same IDLE cycle: hw_reset wins, request not accepted
REQ-021 hw_reset during RST_LOW or RST_WAIT SHALL restart the count from RST_LOW.
REQ-022 Phase counters SHALL be sized to $clog2 of the largest *_CYC value plus 1 and SHALL not wrap.

Reset
REQ-023 While res=1 the outputs SHALL be: CSx=1, RESx=0, DCx=1, WRx=1, RDx=1, DATAx_o=0, DATAx_oe=0, req_ready=0, rsp_valid=0, rsp_data=0, busy=1.
REQ-024 While res=1 the state SHALL be RST_LOW with its counter cleared.
REQ-025 On res deassertion the power-on sequence of REQ-004/005 SHALL run automatically with no request needed.

Verification (bench overrides: RST_LOW_CYC=4, RST_WAIT_CYC=6, WR_LOW_CYC=2, WR_HIGH_CYC=2, RD_LOW_CYC=3, RD_HIGH_CYC=2)
REQ-026 Release res -> RESx=0 for 4 cycles, RESx=1 with busy=1 for 6 cycles, then req_ready=1.
REQ-027 Write cmd 0x0011, last=1 -> CSx=0 and DCx=0 in SETUP; WRx low 2, high 2; DATAx_o=0x0011 with oe=1 throughout; CSx=1 in IDLE; accept to IDLE in 5 cycles.
REQ-028 Burst cmd 0x002C, last=0, then data 0xF800 and 0x07E0, last on the final beat -> CSx continuously 0 across all three beats; DCx 0,1,1; three WRx rising edges; CSx=1 after the third beat.
REQ-029 Read with DATAx_i=0xA5A5 during RD_LOW -> oe=0, RDx low 3 cycles, rsp_valid exactly one pulse, rsp_data=0xA5A5, WRx stays 1.
REQ-030 hw_reset asserted on the second WR_LOW cycle -> next cycle WRx=1, CSx=1, RESx=0; no rsp_valid; full 4+6 reset sequence before req_ready=1.
REQ-031 DATA_W=8 instance, write 0x3A -> DATAx_o=0x3A; same timing as REQ-027.

Source files
------------

// File: rtl/hx8357_dbi_engine.sv
// 8080-style DBI bus engine for HX8357 panels: power-on/commanded reset sequencing
// plus single command/data write and read beats with optional CSx burst hold.
module hx8357_dbi_engine #(
    parameter int DATA_W       = 16,
    parameter int WR_LOW_CYC   = 2,
    parameter int WR_HIGH_CYC  = 2,
    parameter int RD_LOW_CYC   = 8,
    parameter int RD_HIGH_CYC  = 4,
    parameter int RST_LOW_CYC  = 250,
    parameter int RST_WAIT_CYC = 3000000
) (
    input  logic              clk,
    input  logic              res,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_dc,
    input  logic              req_rd,
    input  logic              req_last,
    input  logic [DATA_W-1:0] req_data,
    input  logic              hw_reset,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              CSx,
    output logic              RESx,
    output logic              DCx,
    output logic              WRx,
    output logic              RDx,
    output logic [DATA_W-1:0] DATAx_o,
    output logic              DATAx_oe,
    input  logic [DATA_W-1:0] DATAx_i
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC = max2(max2(max2(WR_LOW_CYC, WR_HIGH_CYC), max2(RD_LOW_CYC, RD_HIGH_CYC)),
                                  max2(RST_LOW_CYC, RST_WAIT_CYC));
    localparam int CNT_W = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] WR_LOW_LAST   = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] WR_HIGH_LAST  = CNT_W'(WR_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LOW_LAST   = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RD_HIGH_LAST  = CNT_W'(RD_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] RST_LOW_LAST  = CNT_W'(RST_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RST_WAIT_LAST = CNT_W'(RST_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        IDLE,
        SETUP,
        WR_LOW,
        WR_HIGH,
        RD_LOW,
        RD_HIGH
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             rd_reg;
    logic             last_reg;
    logic [CNT_W-1:0] phase_last;
    logic             phase_done;

    // Terminal count of the current phase; counters stop here and never wrap.
    always_comb begin
        phase_last = '0;
        case (state_reg)
            RST_LOW:  phase_last = RST_LOW_LAST;
            RST_WAIT: phase_last = RST_WAIT_LAST;
            WR_LOW:   phase_last = WR_LOW_LAST;
            WR_HIGH:  phase_last = WR_HIGH_LAST;
            RD_LOW:   phase_last = RD_LOW_LAST;
            RD_HIGH:  phase_last = RD_HIGH_LAST;
            default:  phase_last = '0;
        endcase
    end

    assign phase_done = (cnt_reg == phase_last);

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_reg <= RST_LOW;
            cnt_reg   <= '0;
            rd_reg    <= 1'b0;
            last_reg  <= 1'b0;
            CSx       <= 1'b1;
            RESx      <= 1'b0;
            DCx       <= 1'b1;
            WRx       <= 1'b1;
            RDx       <= 1'b1;
            DATAx_o   <= '0;
            DATAx_oe  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
        end else if (hw_reset) begin
            // Abort wins over everything, including a same-cycle accept.
            state_reg <= RST_LOW;
            cnt_reg   <= '0;
            CSx       <= 1'b1;
            RESx      <= 1'b0;
            WRx       <= 1'b1;
            RDx       <= 1'b1;
            DATAx_oe  <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                RST_LOW: begin
                    if (phase_done) begin
                        state_reg <= RST_WAIT;
                        RESx      <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RST_WAIT: begin
                    if (phase_done) begin
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (req_valid && req_ready) begin
                        state_reg <= SETUP;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rd_reg    <= req_rd;
                        last_reg  <= req_last;
                        CSx       <= 1'b0;
                        DCx       <= req_dc;
                        DATAx_oe  <= ~req_rd;
                        if (!req_rd) begin
                            DATAx_o <= req_data;
                        end
                    end
                end
                SETUP: begin
                    cnt_reg <= '0;
                    if (rd_reg) begin
                        state_reg <= RD_LOW;
                        RDx       <= 1'b0;
                    end else begin
                        state_reg <= WR_LOW;
                        WRx       <= 1'b0;
                    end
                end
                WR_LOW: begin
                    if (phase_done) begin
                        state_reg <= WR_HIGH;
                        WRx       <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                RD_LOW: begin
                    if (phase_done) begin
                        state_reg <= RD_HIGH;
                        RDx       <= 1'b1;
                        rsp_data  <= DATAx_i;
                        rsp_valid <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                WR_HIGH, RD_HIGH: begin
                    // Beat end: CSx stays low when the burst remains open.
                    if (phase_done) begin
                        state_reg <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        DATAx_oe  <= 1'b0;
                        cnt_reg   <= '0;
                        if (last_reg) begin
                            CSx <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= RST_LOW;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hx8357_dbi_engine.sv
// Scoreboard bench for hx8357_dbi_engine: stimulus queues expected bus beats and read
// data, a negedge monitor pops them at each WRx rising edge / rsp_valid pulse.
module tb_hx8357_dbi_engine;

    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_dc = 1'b0, req_rd = 1'b0, req_last = 1'b0, hw_reset = 1'b0;
    logic [15:0] req_data = '0, DATAx_i = '0;
    logic        req_ready, rsp_valid, busy, CSx, RESx, DCx, WRx, RDx, DATAx_oe;
    logic [15:0] rsp_data, DATAx_o;

    logic        req_valid8 = 1'b0, req_dc8 = 1'b0, req_rd8 = 1'b0, req_last8 = 1'b0, hw_reset8 = 1'b0;
    logic [7:0]  req_data8 = '0, DATAx_i8 = '0;
    logic        req_ready8, rsp_valid8, busy8, CSx8, RESx8, DCx8, WRx8, RDx8, DATAx_oe8;
    logic [7:0]  rsp_data8, DATAx_o8;

    hx8357_dbi_engine #(
        .DATA_W(16), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RD_LOW_CYC(3), .RD_HIGH_CYC(2),
        .RST_LOW_CYC(4), .RST_WAIT_CYC(6)
    ) dut (
        .clk(clk), .res(res), .req_valid(req_valid), .req_ready(req_ready), .req_dc(req_dc),
        .req_rd(req_rd), .req_last(req_last), .req_data(req_data), .hw_reset(hw_reset),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy), .CSx(CSx), .RESx(RESx),
        .DCx(DCx), .WRx(WRx), .RDx(RDx), .DATAx_o(DATAx_o), .DATAx_oe(DATAx_oe), .DATAx_i(DATAx_i)
    );

    hx8357_dbi_engine #(
        .DATA_W(8), .WR_LOW_CYC(2), .WR_HIGH_CYC(2), .RD_LOW_CYC(3), .RD_HIGH_CYC(2),
        .RST_LOW_CYC(4), .RST_WAIT_CYC(6)
    ) dut8 (
        .clk(clk), .res(res), .req_valid(req_valid8), .req_ready(req_ready8), .req_dc(req_dc8),
        .req_rd(req_rd8), .req_last(req_last8), .req_data(req_data8), .hw_reset(hw_reset8),
        .rsp_valid(rsp_valid8), .rsp_data(rsp_data8), .busy(busy8), .CSx(CSx8), .RESx(RESx8),
        .DCx(DCx8), .WRx(WRx8), .RDx(RDx8), .DATAx_o(DATAx_o8), .DATAx_oe(DATAx_oe8), .DATAx_i(DATAx_i8)
    );

    int checks = 0;
    int errors = 0;

    logic [16:0] wr_q[$];   // {dc, data} of each write beat the display should latch
    logic [15:0] rd_q[$];   // read data expected on rsp_data
    logic        burst_chk = 1'b0;
    int          cs_glitch = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: bus beats complete on a WRx/RDx rising edge while CSx is low.
    initial begin
        logic        wr_prev = 1'b1, rd_prev = 1'b1, rv_prev = 1'b0;
        int          wr_run = 0, rd_run = 0;
        logic [16:0] we;
        logic [15:0] re;
        forever begin
            @(negedge clk);
            if (!res) begin
                chk("wr_rd_excl", 32'(WRx | RDx), 1);
                if (burst_chk && CSx) cs_glitch++;
                if (!WRx) begin
                    chk("wr_oe_low", 32'(DATAx_oe), 1);
                    wr_run++;
                end else if (!wr_prev) begin
                    if (!CSx) begin
                        chk("wr_low_len", 32'(wr_run), 2);
                        chk("wr_q_avail", 32'(wr_q.size() != 0), 1);
                        if (wr_q.size() != 0) begin
                            we = wr_q.pop_front();
                            chk("wr_dc", 32'(DCx), 32'(we[16]));
                            chk("wr_data", 32'(DATAx_o), 32'(we[15:0]));
                            chk("wr_oe_rise", 32'(DATAx_oe), 1);
                            $display("write dc=%0d data=%h", DCx, DATAx_o);
                        end
                    end
                    wr_run = 0;
                end
                if (!RDx) begin
                    chk("rd_oe", 32'(DATAx_oe), 0);
                    rd_run++;
                end else if (!rd_prev) begin
                    if (!CSx) chk("rd_low_len", 32'(rd_run), 3);
                    rd_run = 0;
                end
                if (rsp_valid) begin
                    chk("rsp_pulse", 32'(rv_prev), 0);
                    chk("rd_q_avail", 32'(rd_q.size() != 0), 1);
                    if (rd_q.size() != 0) begin
                        re = rd_q.pop_front();
                        chk("rsp_data", 32'(rsp_data), 32'(re));
                        $display("read data=%h", rsp_data);
                    end
                end
                wr_prev = WRx;
                rd_prev = RDx;
                rv_prev = rsp_valid;
            end
        end
    end

    // Called with the DUT in its first RST_LOW cycle.
    task automatic measure_reset(input string tag);
        int nl = 0, nw = 0, g = 0;
        while (!RESx && g < 100) begin
            chk({tag, "_cs_low"}, 32'(CSx), 1);
            nl++; g++; step();
        end
        while (RESx && busy && !req_ready && g < 100) begin
            nw++; g++; step();
        end
        chk({tag, "_res_low_cyc"}, 32'(nl), 4);
        chk({tag, "_wait_cyc"}, 32'(nw), 6);
        chk({tag, "_ready"}, 32'(req_ready), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        $display("reset sequence %s low=%0d wait=%0d", tag, nl, nw);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 200) begin step(); n++; end
        chk("ready_wait", 32'(req_ready), 1);
    endtask

    task automatic send(input logic dc, input logic rd, input logic last,
                        input logic [15:0] data, input logic [15:0] din);
        int n = 0;
        wait_ready();
        if (rd) rd_q.push_back(din);
        else    wr_q.push_back({dc, data});
        req_valid = 1'b1; req_dc = dc; req_rd = rd; req_last = last; req_data = data; DATAx_i = din;
        step();
        req_valid = 1'b0;
        do begin step(); n++; end while (!req_ready && n < 50);
        chk("beat_len", 32'(n), rd ? 32'd6 : 32'd5);
        chk("cs_idle", 32'(CSx), 32'(last));
    endtask

    task automatic start_abortable(input logic rd);
        wait_ready();
        req_valid = 1'b1; req_dc = 1'b1; req_rd = rd; req_last = 1'b1; req_data = 16'h1234;
        DATAx_i = 16'h5A5A;
        step();
        req_valid = 1'b0;
    endtask

    task automatic hw_pulse();
        hw_reset = 1'b1;
        step();
        hw_reset = 1'b0;
    endtask

    initial begin
        logic [5:0] wr8_exp = 6'b111001;
        logic [5:0] cs8_exp = 6'b100000;
        logic [5:0] oe8_exp = 6'b011111;
        logic [5:0] rdy8_exp = 6'b100000;
        int         g;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", 32'(CSx), 1);
        chk("rst_res", 32'(RESx), 0);
        chk("rst_dc", 32'(DCx), 1);
        chk("rst_wr", 32'(WRx), 1);
        chk("rst_rd", 32'(RDx), 1);
        chk("rst_data_o", 32'(DATAx_o), 0);
        chk("rst_oe", 32'(DATAx_oe), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_busy", 32'(busy), 1);
        res = 1'b0;
        measure_reset("por");

        send(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000);

        send(1'b0, 1'b0, 1'b0, 16'h002C, 16'h0000);
        burst_chk = 1'b1;
        send(1'b1, 1'b0, 1'b0, 16'hF800, 16'h0000);
        send(1'b1, 1'b0, 1'b1, 16'h07E0, 16'h0000);
        burst_chk = 1'b0;
        chk("burst_cs_glitch", 32'(cs_glitch), 0);

        send(1'b1, 1'b1, 1'b1, 16'h0000, 16'hA5A5);

        for (int i = 0; i < 30; i++) begin
            send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                 16'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 2)) step();
        end

        // Abort a write on its second WR_LOW cycle.
        start_abortable(1'b0);
        step(); step();
        hw_reset = 1'b1;
        step();
        hw_reset = 1'b0;
        chk("abort_wr_wrx", 32'(WRx), 1);
        chk("abort_wr_csx", 32'(CSx), 1);
        chk("abort_wr_resx", 32'(RESx), 0);
        chk("abort_wr_oe", 32'(DATAx_oe), 0);
        measure_reset("abort_wr");

        // Abort a read on the cycle that would have sampled the bus.
        start_abortable(1'b1);
        step(); step(); step();
        hw_reset = 1'b1;
        step();
        hw_reset = 1'b0;
        chk("abort_rd_rdx", 32'(RDx), 1);
        chk("abort_rd_rsp_valid", 32'(rsp_valid), 0);
        measure_reset("abort_rd");

        // hw_reset and req_valid together in IDLE.
        wait_ready();
        req_valid = 1'b1; req_rd = 1'b0; req_dc = 1'b0; req_last = 1'b1; req_data = 16'hBEEF;
        hw_reset = 1'b1;
        step();
        req_valid = 1'b0;
        hw_reset = 1'b0;
        chk("tie_ready", 32'(req_ready), 0);
        chk("tie_csx", 32'(CSx), 1);
        chk("tie_resx", 32'(RESx), 0);
        measure_reset("tie");

        // hw_reset in the middle of RST_WAIT restarts from RST_LOW.
        hw_pulse();
        g = 0;
        while (!RESx && g < 100) begin step(); g++; end
        step(); step();
        chk("restart_in_wait", 32'(RESx & busy), 1);
        hw_pulse();
        measure_reset("restart");

        repeat (5) step();
        chk("wr_q_empty", 32'(wr_q.size()), 0);
        chk("rd_q_empty", 32'(rd_q.size()), 0);

        // Narrow-bus instance: same timing as the 16-bit write.
        g = 0;
        while (!req_ready8 && g < 200) begin step(); g++; end
        chk("w8_ready", 32'(req_ready8), 1);
        req_valid8 = 1'b1; req_dc8 = 1'b0; req_rd8 = 1'b0; req_last8 = 1'b1; req_data8 = 8'h3A;
        step();
        req_valid8 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("w8_wrx", 32'(WRx8), 32'(wr8_exp[k]));
            chk("w8_csx", 32'(CSx8), 32'(cs8_exp[k]));
            chk("w8_oe", 32'(DATAx_oe8), 32'(oe8_exp[k]));
            chk("w8_ready_t", 32'(req_ready8), 32'(rdy8_exp[k]));
            if (k < 5) begin
                chk("w8_data", 32'(DATAx_o8), 32'h3A);
                chk("w8_dcx", 32'(DCx8), 0);
            end
            if (k < 5) step();
        end
        $display("write8 data=%h", DATAx_o8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
